// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus between the fetch unit and instruction memory:
// one valid/ready request channel and one valid-only response channel.
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  // Fetch unit side: issues requests, receives responses.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Memory side: accepts requests, returns instruction words.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one memory request in
// flight, presents the fetched word with its PC downstream, and discards
// responses made stale by a branch/jump redirect.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  ifetch_unit_if.master       imem,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  input  logic                stall,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [31:0]         inst_pc
);

  // Word alignment is enforced on every PC source so the request address is
  // always a legal word address.
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_AL  = RESET_PC & ALIGN_MASK;
  localparam logic [31:0] PC_INC       = 32'(PC_STEP);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    OUT  = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] inst_r;
  logic [31:0] inst_next_s;
  logic [31:0] inst_pc_r;
  logic [31:0] inst_pc_next_s;
  logic        inst_valid_r;
  logic        inst_valid_next_s;
  logic        req_valid_r;
  logic [31:0] redir_pc_s;

  assign redir_pc_s = redirect_pc & ALIGN_MASK;

  // Next-state, next-PC and output-register logic for the fetch FSM.
  always_comb begin
    next_state_s      = state_r;
    pc_next_s         = pc_r;
    inst_next_s       = inst_r;
    inst_pc_next_s    = inst_pc_r;
    inst_valid_next_s = inst_valid_r;

    case (state_r)
      IDLE: begin
        next_state_s = REQ;
      end

      REQ: begin
        if (imem.imem_req_ready) begin
          if (redirect_valid) begin
            // Request already accepted for the old PC: its response is stale.
            pc_next_s    = redir_pc_s;
            next_state_s = DROP;
          end else begin
            next_state_s = WAIT;
          end
        end else begin
          if (redirect_valid) begin
            // Not yet accepted, so the address may simply change under valid.
            pc_next_s = redir_pc_s;
          end else begin
            pc_next_s = pc_r;
          end
          next_state_s = REQ;
        end
      end

      WAIT: begin
        if (imem.imem_rsp_valid) begin
          if (redirect_valid) begin
            // Response and redirect together: data belongs to the old path.
            pc_next_s    = redir_pc_s;
            next_state_s = REQ;
          end else begin
            inst_next_s       = imem.imem_rsp_data;
            inst_pc_next_s    = pc_r;
            inst_valid_next_s = 1'b1;
            pc_next_s         = pc_r + PC_INC;
            next_state_s      = OUT;
          end
        end else begin
          if (redirect_valid) begin
            pc_next_s    = redir_pc_s;
            next_state_s = DROP;
          end else begin
            next_state_s = WAIT;
          end
        end
      end

      OUT: begin
        if (redirect_valid) begin
          // Redirect wins over stall: the held instruction is on a dead path.
          inst_valid_next_s = 1'b0;
          pc_next_s         = redir_pc_s;
          next_state_s      = REQ;
        end else if (!stall) begin
          inst_valid_next_s = 1'b0;
          next_state_s      = REQ;
        end else begin
          next_state_s = OUT;
        end
      end

      DROP: begin
        if (redirect_valid) begin
          pc_next_s = redir_pc_s;
        end else begin
          pc_next_s = pc_r;
        end
        if (imem.imem_rsp_valid) begin
          // Stale response swallowed; now free to issue the new address.
          next_state_s = REQ;
        end else begin
          next_state_s = DROP;
        end
      end

      default: begin
        next_state_s      = IDLE;
        inst_valid_next_s = 1'b0;
      end
    endcase
  end

  // State, PC and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC_AL;
      inst_r       <= 32'h0000_0000;
      inst_pc_r    <= 32'h0000_0000;
      inst_valid_r <= 1'b0;
      req_valid_r  <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      pc_r         <= pc_next_s;
      inst_r       <= inst_next_s;
      inst_pc_r    <= inst_pc_next_s;
      inst_valid_r <= inst_valid_next_s;
      // Registered copy of (state == REQ) so the request valid is glitch-free.
      req_valid_r  <= (next_state_s == REQ);
    end
  end

  assign imem.imem_req_valid = req_valid_r;
  assign imem.imem_req_addr  = pc_r;
  assign inst_valid          = inst_valid_r;
  assign inst                = inst_r;
  assign inst_pc             = inst_pc_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a small behavioural instruction memory
// whose response data is the request address XOR 32'hA5A5_0000.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  ifetch_unit_if bus ();

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model state: one pending request, responding after lat extra cycles.
  logic        pend;
  logic [31:0] paddr;
  int          cnt;
  int          lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the memory model then updates its response for the next edge.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    logic        rsp_was;
    hs      = bus.imem_req_valid && bus.imem_req_ready;
    a       = bus.imem_req_addr;
    rsp_was = bus.imem_rsp_valid;
    @(posedge clk);
    #1;
    if (rsp_was) pend = 1'b0;
    if (hs) begin
      pend  = 1'b1;
      paddr = a;
      cnt   = lat;
    end else if (pend && cnt > 0) begin
      cnt--;
    end
    bus.imem_rsp_valid = pend && (cnt == 0);
    bus.imem_rsp_data  = paddr ^ KEY;
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] data, input int gap);
    for (int i = 0; i < gap - 1; i++) begin
      tick();
      check32("gap_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
    tick();
    check32("inst_valid", {31'd0, inst_valid}, 32'd1);
    check32("inst_pc", inst_pc, pc);
    check32("inst", inst, data);
  endtask

  initial begin
    rst                = 1'b1;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0000_0000;
    stall              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0000_0000;
    pend  = 1'b0;
    paddr = 32'h0000_0000;
    cnt   = 0;
    lat   = 0;

    // Reset state.
    tick();
    tick();
    check32("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check32("rst_inst", inst, 32'h0000_0000);
    check32("rst_inst_pc", inst_pc, 32'h0000_0000);
    check32("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    rst = 1'b0;

    // First request appears on the second cycle after release.
    tick();
    check32("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("first_req_addr", bus.imem_req_addr, 32'h0000_0000);

    // Free run: 0, 4, 8 at 3-cycle spacing.
    expect_inst(32'h0000_0000, 32'hA5A5_0000, 2);
    expect_inst(32'h0000_0004, 32'hA5A5_0004, 3);
    expect_inst(32'h0000_0008, 32'hA5A5_0008, 3);

    // Stall four cycles while holding inst_pc = 8.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check32("stall_valid", {31'd0, inst_valid}, 32'd1);
      check32("stall_pc", inst_pc, 32'h0000_0008);
      check32("stall_inst", inst, 32'hA5A5_0008);
      check32("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check32("post_stall_valid", {31'd0, inst_valid}, 32'd0);
    check32("post_stall_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("post_stall_addr", bus.imem_req_addr, 32'h0000_000C);

    // Redirect to 0x100 while waiting; late response for 0xC must be dropped.
    lat = 1;
    tick();
    check32("wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check32("drop_valid0", {31'd0, inst_valid}, 32'd0);
    check32("drop_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    check32("drop_valid1", {31'd0, inst_valid}, 32'd0);
    check32("drop_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("drop_addr", bus.imem_req_addr, 32'h0000_0100);
    lat = 0;
    expect_inst(32'h0000_0100, 32'hA5A5_0100, 2);

    // Redirect coincident with the response; misaligned target gets aligned.
    tick();
    check32("seq_addr_104", bus.imem_req_addr, 32'h0000_0104);
    tick();
    check32("coinc_rsp_present", {31'd0, bus.imem_rsp_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check32("coinc_valid", {31'd0, inst_valid}, 32'd0);
    check32("coinc_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("coinc_addr", bus.imem_req_addr, 32'h0000_0100);
    expect_inst(32'h0000_0100, 32'hA5A5_0100, 2);

    // Redirect in OUT beats stall; target near top of address space.
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check32("out_redir_valid", {31'd0, inst_valid}, 32'd0);
    check32("out_redir_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    expect_inst(32'hFFFF_FFFC, 32'h5A5A_FFFC, 2);
    tick();
    check32("wrap_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

    // Reset in WAIT with the response arriving during reset recovery.
    lat = 1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check32("rstw_rsp_present", {31'd0, bus.imem_rsp_valid}, 32'd1);
    check32("rstw_valid0", {31'd0, inst_valid}, 32'd0);
    check32("rstw_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    check32("rstw_valid1", {31'd0, inst_valid}, 32'd0);
    check32("rstw_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("rstw_addr", bus.imem_req_addr, 32'h0000_0000);
    lat = 0;

    // Memory not ready: request held, then redirected while still pending.
    bus.imem_req_ready = 1'b0;
    tick();
    check32("nordy_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("nordy_addr", bus.imem_req_addr, 32'h0000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check32("nordy_redir_req", {31'd0, bus.imem_req_valid}, 32'd1);
    check32("nordy_redir_addr", bus.imem_req_addr, 32'h0000_0200);
    bus.imem_req_ready = 1'b1;
    expect_inst(32'h0000_0200, 32'hA5A5_0200, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
